hazard_ctrl_unit: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core; companion to the operand forwarding logic.

---
 rtl/hazard_ctrl_unit.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, memory freeze and handshake timeout.
// Optional macro STORE_DATA_FWD_EN: a store's rs2 (data) match does not cause a load-use stall.
module hazard_ctrl_unit #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_mem_read,
    input  logic [4:0]       ID_EX_rd,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             IF_ID_mem_write,
    input  logic             branch_taken,
    input  logic             EX_MEM_mem_req,
    input  logic             dmem_ready,
    output logic             pc_write_en,
    output logic             IF_ID_write_en,
    output logic             ID_EX_write_en,
    output logic             EX_MEM_write_en,
    output logic             MEM_WB_write_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WaitLimit = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {StRun, StMemWait, StTimeout} state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
    logic              freeze, frozen, rs1_hit, rs2_hit, load_use;
    logic              stall_evt, flush_evt;

    assign freeze  = EX_MEM_mem_req & ~dmem_ready;
    assign frozen  = (state_q == StTimeout) | freeze;
    assign rs1_hit = IF_ID_use_rs1 & (ID_EX_rd == IF_ID_rs1);
`ifdef STORE_DATA_FWD_EN
    // Store data is forwarded MEM/WB->MEM, so only the address operand needs the load result.
    assign rs2_hit = IF_ID_use_rs2 & (ID_EX_rd == IF_ID_rs2) & ~IF_ID_mem_write;
`else
    assign rs2_hit = IF_ID_use_rs2 & (ID_EX_rd == IF_ID_rs2);
`endif
    assign load_use = ID_EX_mem_read & (ID_EX_rd != 5'd0) & (rs1_hit | rs2_hit);

    // Entering the wait from RUN counts the first frozen cycle; saturate so MAX_WAIT=0 never wraps.
    assign wait_inc = (state_q == StRun) ? WAIT_W'(1) :
                      ((wait_q == '1) ? wait_q : wait_q + 1'b1);

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        stall_evt       = 1'b0;
        flush_evt       = 1'b0;
        pc_write_en     = 1'b1;
        IF_ID_write_en  = 1'b1;
        ID_EX_write_en  = 1'b1;
        EX_MEM_write_en = 1'b1;
        MEM_WB_write_en = 1'b1;
        IF_ID_flush     = 1'b0;
        ID_EX_flush     = 1'b0;

        if (frozen) begin
            pc_write_en     = 1'b0;
            IF_ID_write_en  = 1'b0;
            ID_EX_write_en  = 1'b0;
            EX_MEM_write_en = 1'b0;
            MEM_WB_write_en = 1'b0;
            stall_evt       = 1'b1;
            if (state_q != StTimeout) begin
                wait_d = wait_inc;
                if ((MAX_WAIT != 0) && (wait_inc == WaitLimit)) begin
                    state_d = StTimeout;
                end else begin
                    state_d = StMemWait;
                end
            end
        end else begin
            state_d = StRun;
            wait_d  = '0;
            if (branch_taken) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                flush_evt   = 1'b1;
            end else if (load_use) begin
                pc_write_en    = 1'b0;
                IF_ID_write_en = 1'b0;
                ID_EX_flush    = 1'b1;
                stall_evt      = 1'b1;
            end
        end

        stall_d = (stall_evt && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush_evt && flush_q != '1) ? flush_q + 1'b1 : flush_q;

        if (rst) begin
            pc_write_en     = 1'b0;
            IF_ID_write_en  = 1'b0;
            ID_EX_write_en  = 1'b0;
            EX_MEM_write_en = 1'b0;
            MEM_WB_write_en = 1'b0;
            IF_ID_flush     = 1'b1;
            ID_EX_flush     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign mem_timeout = (state_q == StTimeout);
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus random stimulus against a cycle model.
module tb_hazard_ctrl_unit;

    localparam int unsigned CNT_W    = 5;
    localparam int unsigned MAX_WAIT = 4;
    localparam int          CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             ID_EX_mem_read;
    logic [4:0]       ID_EX_rd, IF_ID_rs1, IF_ID_rs2;
    logic             IF_ID_use_rs1, IF_ID_use_rs2, IF_ID_mem_write;
    logic             branch_taken, EX_MEM_mem_req, dmem_ready;
    logic             pc_write_en, IF_ID_write_en, ID_EX_write_en, EX_MEM_write_en;
    logic             MEM_WB_write_en, IF_ID_flush, ID_EX_flush, mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    // Model state: consecutive frozen cycles, sticky timeout, event counts.
    int m_run   = 0;
    bit m_to    = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl_unit #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_EX_mem_read  (ID_EX_mem_read),
        .ID_EX_rd        (ID_EX_rd),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2),
        .IF_ID_use_rs1   (IF_ID_use_rs1),
        .IF_ID_use_rs2   (IF_ID_use_rs2),
        .IF_ID_mem_write (IF_ID_mem_write),
        .branch_taken    (branch_taken),
        .EX_MEM_mem_req  (EX_MEM_mem_req),
        .dmem_ready      (dmem_ready),
        .pc_write_en     (pc_write_en),
        .IF_ID_write_en  (IF_ID_write_en),
        .ID_EX_write_en  (ID_EX_write_en),
        .EX_MEM_write_en (EX_MEM_write_en),
        .MEM_WB_write_en (MEM_WB_write_en),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        bit hit1, hit2;
        hit1 = IF_ID_use_rs1 && (ID_EX_rd == IF_ID_rs1);
        hit2 = IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2);
`ifdef STORE_DATA_FWD_EN
        if (IF_ID_mem_write) hit2 = 0;
`endif
        return ID_EX_mem_read && (ID_EX_rd != 0) && (hit1 || hit2);
    endfunction

    // {pc, IF_ID, ID_EX, EX_MEM, MEM_WB enables, IF_ID_flush, ID_EX_flush}
    function automatic logic [6:0] model_ctl();
        if (rst) return 7'b00000_11;
        if (m_to || (EX_MEM_mem_req && !dmem_ready)) return 7'b00000_00;
        if (branch_taken) return 7'b11111_11;
        if (model_load_use()) return 7'b00111_01;
        return 7'b11111_00;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_run = 0; m_to = 0; m_stall = 0; m_flush = 0;
        end else if (m_to) begin
            m_stall = sat_inc(m_stall);
        end else if (EX_MEM_mem_req && !dmem_ready) begin
            m_stall = sat_inc(m_stall);
            m_run++;
            if (MAX_WAIT != 0 && m_run >= MAX_WAIT) m_to = 1;
        end else begin
            m_run = 0;
            if (branch_taken) m_flush = sat_inc(m_flush);
            else if (model_load_use()) m_stall = sat_inc(m_stall);
        end
    endtask

    // Check mid-cycle, advance the model on the edge, then release for new stimulus.
    task automatic step();
        @(negedge clk);
        check_eq("ctl", {pc_write_en, IF_ID_write_en, ID_EX_write_en, EX_MEM_write_en,
                         MEM_WB_write_en, IF_ID_flush, ID_EX_flush}, model_ctl());
        check_eq("stall_count", stall_count, m_stall);
        check_eq("flush_count", flush_count, m_flush);
        check_eq("mem_timeout", mem_timeout, m_to);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        rst = 0; ID_EX_mem_read = 0; ID_EX_rd = 0; IF_ID_rs1 = 0; IF_ID_rs2 = 0;
        IF_ID_use_rs1 = 0; IF_ID_use_rs2 = 0; IF_ID_mem_write = 0; branch_taken = 0;
        EX_MEM_mem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        set_idle();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        check_eq("rst_stall", stall_count, 0);
        check_eq("rst_flush", flush_count, 0);

        // Load-use on rs1
        ID_EX_mem_read = 1; ID_EX_rd = 5; IF_ID_rs1 = 5; IF_ID_use_rs1 = 1;
        step();
        check_eq("lu_stall", stall_count, 1);
        set_idle();
        step();

        // Branch wins over a simultaneous load-use
        ID_EX_mem_read = 1; ID_EX_rd = 5; IF_ID_rs1 = 5; IF_ID_use_rs1 = 1; branch_taken = 1;
        step();
        check_eq("br_flush", flush_count, 1);
        check_eq("br_stall", stall_count, 1);
        set_idle();

        // Three frozen cycles, then memory completes
        EX_MEM_mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) step();
        dmem_ready = 1;
        step();
        check_eq("mw_stall", stall_count, 4);
        check_eq("mw_tmo", mem_timeout, 0);
        set_idle();

        // Load then store depending via data only, then via address
        ID_EX_mem_read = 1; ID_EX_rd = 7; IF_ID_mem_write = 1;
        IF_ID_rs1 = 2; IF_ID_rs2 = 7; IF_ID_use_rs1 = 1; IF_ID_use_rs2 = 1;
        #1;
`ifdef STORE_DATA_FWD_EN
        check_eq("st_data_flush", ID_EX_flush, 0);
        check_eq("st_data_pc", pc_write_en, 1);
`else
        check_eq("st_data_flush", ID_EX_flush, 1);
        check_eq("st_data_pc", pc_write_en, 0);
`endif
        step();
        IF_ID_rs1 = 7; IF_ID_rs2 = 3;
        #1;
        check_eq("st_addr_flush", ID_EX_flush, 1);
        check_eq("st_addr_pc", pc_write_en, 0);
        step();
        set_idle();
        step();

        // Timeout after MAX_WAIT frozen cycles, sticky across dmem_ready
        EX_MEM_mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) step();
        check_eq("tmo_early", mem_timeout, 0);
        step();
        check_eq("tmo_set", mem_timeout, 1);
        dmem_ready = 1;
        step();
        check_eq("tmo_hold", mem_timeout, 1);
        check_eq("tmo_pc", pc_write_en, 0);
        for (int i = 0; i < 35; i++) step();
        check_eq("stall_sat", stall_count, CMAX);
        set_idle();
        rst = 1;
        step();
        rst = 0;
        step();
        check_eq("tmo_clr", mem_timeout, 0);
        check_eq("tmo_clr_stall", stall_count, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 39) == 0);
            ID_EX_mem_read  = $urandom_range(0, 1);
            ID_EX_rd        = 5'($urandom_range(0, 3));
            IF_ID_rs1       = 5'($urandom_range(0, 3));
            IF_ID_rs2       = 5'($urandom_range(0, 3));
            IF_ID_use_rs1   = $urandom_range(0, 1);
            IF_ID_use_rs2   = $urandom_range(0, 1);
            IF_ID_mem_write = $urandom_range(0, 1);
            branch_taken    = ($urandom_range(0, 5) == 0);
            EX_MEM_mem_req  = ($urandom_range(0, 2) == 0);
            dmem_ready      = $urandom_range(0, 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
